// File: rtl/post_adder_preg_if.sv
// Bundle of enables, mux operands, carry-in sources and results around the DSP post-adder.
// The slave modport is the adder stage; the master drives its operands.
interface post_adder_preg_if;
   logic        cecarryin;
   logic        cep;
   logic [47:0] x_in;
   logic [47:0] z_in;
   logic        opmode7;
   logic        opmode5;
   logic        carryin;
   logic [47:0] p;
   logic [47:0] pcout;
   logic        carryout;
   logic        carryoutf;

   modport master (
      output cecarryin, cep, x_in, z_in, opmode7, opmode5, carryin,
      input  p, pcout, carryout, carryoutf
   );

   modport slave (
      input  cecarryin, cep, x_in, z_in, opmode7, opmode5, carryin,
      output p, pcout, carryout, carryoutf
   );
endinterface

// File: rtl/post_adder_preg.sv
// DSP48A1-style post-adder/subtractor: P = Z +/- (X + CIN), with optional CYI, P and
// CARRYOUT registers. All registers use a synchronous active-high reset.
module post_adder_preg #(
   parameter int unsigned PREG        = 1,
   parameter int unsigned CARRYOUTREG = 1,
   parameter int unsigned CARRYINREG  = 1,
   parameter string       CARRYINSEL  = "OPMODE5"
) (
   input logic              clk,
   input logic              rst,
   post_adder_preg_if.slave bus
);

   localparam bit SelOpmode5 = (CARRYINSEL == "OPMODE5");
   localparam bit SelCarryin = (CARRYINSEL == "CARRYIN");

   logic        cin_src;
   logic        cin;
   logic [48:0] addend;
   logic [48:0] sum49;
   logic [47:0] p_int;
   logic        co_int;

   // An unrecognised CARRYINSEL leaves both selects low, forcing the carry-in to zero.
   always_comb begin
      cin_src = (SelOpmode5 & bus.opmode5) | (SelCarryin & bus.carryin);
   end

   if (CARRYINREG != 0) begin : g_cyi
      logic cyi_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            cyi_q <= 1'b0;
         end else if (bus.cecarryin) begin
            cyi_q <= cin_src;
         end
      end
      assign cin = cyi_q;
   end else begin : g_cyi_bypass
      assign cin = cin_src;
   end

   // Bit 48 is the carry on add and the borrow on subtract.
   always_comb begin
      addend = {1'b0, bus.x_in} + {48'd0, cin};
      if (bus.opmode7) begin
         sum49 = {1'b0, bus.z_in} - addend;
      end else begin
         sum49 = {1'b0, bus.z_in} + addend;
      end
   end

   if (PREG != 0) begin : g_preg
      logic [47:0] p_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            p_q <= 48'd0;
         end else if (bus.cep) begin
            p_q <= sum49[47:0];
         end
      end
      assign p_int = p_q;
   end else begin : g_preg_bypass
      assign p_int = sum49[47:0];
   end

   if (CARRYOUTREG != 0) begin : g_coreg
      logic co_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            co_q <= 1'b0;
         end else if (bus.cep) begin
            co_q <= sum49[48];
         end
      end
      assign co_int = co_q;
   end else begin : g_coreg_bypass
      assign co_int = sum49[48];
   end

   assign bus.p         = p_int;
   assign bus.pcout     = p_int;
   assign bus.carryout  = co_int;
   assign bus.carryoutf = co_int;

endmodule

// File: tb/tb_post_adder_preg.sv
// Directed bench for post_adder_preg in three configurations: default registered,
// registered CARRYIN-sourced carry, and fully combinational.
module tb_post_adder_preg;

   logic clk = 1'b0;
   logic rst;
   int   total  = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   post_adder_preg_if ifa ();
   post_adder_preg_if ifb ();
   post_adder_preg_if ifc ();

   post_adder_preg u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   post_adder_preg #(
      .PREG        (1),
      .CARRYOUTREG (1),
      .CARRYINREG  (1),
      .CARRYINSEL  ("CARRYIN")
   ) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   post_adder_preg #(
      .PREG        (0),
      .CARRYOUTREG (0),
      .CARRYINREG  (0),
      .CARRYINSEL  ("OPMODE5")
   ) u_dut_c (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_a(input string tag, input logic [47:0] ep, input logic eco);
      chk({tag, "_p"}, ifa.p, ep);
      chk({tag, "_pcout"}, ifa.pcout, ep);
      chk({tag, "_co"}, {47'd0, ifa.carryout}, {47'd0, eco});
      chk({tag, "_cof"}, {47'd0, ifa.carryoutf}, {47'd0, eco});
   endtask

   task automatic chk_b(input string tag, input logic [47:0] ep, input logic eco);
      chk({tag, "_p"}, ifb.p, ep);
      chk({tag, "_pcout"}, ifb.pcout, ep);
      chk({tag, "_co"}, {47'd0, ifb.carryout}, {47'd0, eco});
      chk({tag, "_cof"}, {47'd0, ifb.carryoutf}, {47'd0, eco});
   endtask

   task automatic chk_c(input string tag, input logic [47:0] ep, input logic eco);
      chk({tag, "_p"}, ifc.p, ep);
      chk({tag, "_pcout"}, ifc.pcout, ep);
      chk({tag, "_co"}, {47'd0, ifc.carryout}, {47'd0, eco});
      chk({tag, "_cof"}, {47'd0, ifc.carryoutf}, {47'd0, eco});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [47:0] acc;
      rst = 1'b1;
      ifa.cecarryin = 1'b1; ifa.cep = 1'b1; ifa.opmode7 = 1'b0; ifa.opmode5 = 1'b0;
      ifa.carryin = 1'b0; ifa.x_in = 48'hFFFF_FFFF_FFFF; ifa.z_in = 48'hFFFF_FFFF_FFFF;
      ifb.cecarryin = 1'b1; ifb.cep = 1'b1; ifb.opmode7 = 1'b0; ifb.opmode5 = 1'b0;
      ifb.carryin = 1'b0; ifb.x_in = 48'd0; ifb.z_in = 48'd0;
      ifc.cecarryin = 1'b1; ifc.cep = 1'b1; ifc.opmode7 = 1'b0; ifc.opmode5 = 1'b0;
      ifc.carryin = 1'b0; ifc.x_in = 48'd0; ifc.z_in = 48'd0;

      // Reset held two edges with all-ones operands and cep high.
      step();
      step();
      chk_a("rst_a", 48'd0, 1'b0);
      chk_b("rst_b", 48'd0, 1'b0);
      rst = 1'b0;
      step();
      chk_a("first_add", 48'hFFFF_FFFF_FFFE, 1'b1);
      chk_b("b_idle", 48'd0, 1'b0);

      // Registered carryin reaches the output two edges later.
      ifb.z_in = 48'hFFFF_FFFF_FFFF; ifb.x_in = 48'd0; ifb.carryin = 1'b1;
      step();
      chk_b("cin_edge1", 48'hFFFF_FFFF_FFFF, 1'b0);
      step();
      chk_b("cin_edge2", 48'd0, 1'b1);

      // Subtract with and without borrow.
      ifa.opmode7 = 1'b1; ifa.z_in = 48'd5; ifa.x_in = 48'd7;
      step();
      chk_a("sub_borrow", 48'hFFFF_FFFF_FFFE, 1'b1);
      ifa.z_in = 48'd7; ifa.x_in = 48'd5;
      step();
      chk_a("sub_plain", 48'd2, 1'b0);

      // cep low holds p and carryout.
      ifa.opmode7 = 1'b0; ifa.z_in = 48'd10; ifa.x_in = 48'd0;
      step();
      chk_a("load10", 48'd10, 1'b0);
      ifa.cep = 1'b0; ifa.x_in = 48'd100;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_a("cep_hold", 48'd10, 1'b0);
      end

      // cecarryin low holds cyi_q through an opmode5 toggle.
      ifa.cep = 1'b1; ifa.x_in = 48'd0; ifa.opmode5 = 1'b1;
      step();
      chk_a("cyi_load", 48'd10, 1'b0);
      step();
      chk_a("cyi_used", 48'd11, 1'b0);
      ifa.cecarryin = 1'b0; ifa.opmode5 = 1'b0;
      step();
      chk_a("cyi_hold1", 48'd11, 1'b0);
      step();
      chk_a("cyi_hold2", 48'd11, 1'b0);
      ifa.cecarryin = 1'b1;
      step();
      chk_a("cyi_reload", 48'd11, 1'b0);
      step();
      chk_a("cyi_cleared", 48'd10, 1'b0);

      // Accumulate loop with z_in fed from the bench model, then reset mid-run.
      rst = 1'b1;
      step();
      chk_a("acc_rst", 48'd0, 1'b0);
      rst = 1'b0;
      acc = 48'd0;
      ifa.x_in = 48'd3;
      for (int i = 0; i < 4; i++) begin
         ifa.z_in = acc;
         step();
         acc = acc + 48'd3;
         chk_a("acc", acc, 1'b0);
      end
      ifa.z_in = acc;
      rst = 1'b1;
      step();
      chk_a("acc_reset", 48'd0, 1'b0);
      rst = 1'b0;

      // Fully combinational configuration responds within the cycle.
      ifc.z_in = 48'd1; ifc.x_in = 48'd2; ifc.opmode5 = 1'b1; ifc.opmode7 = 1'b0;
      #1;
      chk_c("comb_add", 48'd4, 1'b0);
      ifc.opmode7 = 1'b1;
      #1;
      chk_c("comb_sub", 48'hFFFF_FFFF_FFFE, 1'b1);
      ifc.opmode7 = 1'b0; ifc.z_in = 48'hFFFF_FFFF_FFFF; ifc.x_in = 48'd0;
      #1;
      chk_c("comb_wrap", 48'd0, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
